// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle-sequencing controller.
// Holds the FSM state encoding and the select-line meanings seen by the datapath.
package pbs_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        WAIT_MOVE,
        P_CALC,
        P_APPLY,
        P_CHECK,
        AI_THINK,
        AI_CALC,
        AI_APPLY,
        AI_CHECK,
        DONE
    } state_t;

    localparam logic TGT_PLAYER  = 1'b0;
    localparam logic TGT_AI      = 1'b1;
    localparam logic ACTR_PLAYER = 1'b0;
    localparam logic ACTR_AI     = 1'b1;

    localparam int HP_W_DEF   = 4;
    localparam int MOVE_W_DEF = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pbs_wait_cnt.sv
// Loadable down-counter used for both the AI think delay and the HP settle delay.
// Holds at zero once it gets there; a load always wins over counting.
module pbs_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pbs_ctrl.sv
// Battle sequencer: takes the player's move, alternates player and AI attacks,
// watches both HP values after each apply and declares the winner.
module pbs_ctrl
    import pbs_pkg::*;
#(
    parameter int HP_W          = HP_W_DEF,
    parameter int MOVE_W        = MOVE_W_DEF,
    parameter int THINK_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_TURNS     = 15,
    parameter int TURN_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              move_valid,
    input  logic [MOVE_W-1:0] p_move,
    output logic              move_ready,
    output logic [MOVE_W-1:0] p_move_out,
    input  logic [HP_W-1:0]   p_hp,
    input  logic [HP_W-1:0]   AI_hp,
    output logic              dp_rst,
    output logic              target,
    output logic              actr,
    output logic              calc_dmg,
    output logic              app_dmg,
    output logic [TURN_W-1:0] turn_cnt,
    output logic              game_over,
    output logic              player_won
);

    localparam int CNT_MAX = max2(THINK_CYCLES, SETTLE_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  THINK_LD  = CNT_W'(THINK_CYCLES - 1);
    localparam logic [TURN_W-1:0] TURN_LIM  = TURN_W'(MAX_TURNS);

    state_t            state_q;
    state_t            state_d;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;
    logic [TURN_W-1:0] turn_nxt;

    assign turn_nxt = turn_cnt + 1'b1;

    pbs_wait_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Handshake: a move is taken on a cycle where move_valid && move_ready;
    // move_ready is high only in WAIT_MOVE, so valid elsewhere is ignored.
    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        dp_rst     = 1'b0;
        target     = TGT_PLAYER;
        actr       = ACTR_PLAYER;
        calc_dmg   = 1'b0;
        app_dmg    = 1'b0;
        move_ready = 1'b0;
        game_over  = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = INIT;
            INIT: begin
                dp_rst  = 1'b1;
                state_d = WAIT_MOVE;
            end
            WAIT_MOVE: begin
                move_ready = 1'b1;
                if (move_valid) state_d = P_CALC;
            end
            P_CALC: begin
                target   = TGT_AI;
                calc_dmg = 1'b1;
                state_d  = P_APPLY;
            end
            P_APPLY: begin
                target   = TGT_AI;
                app_dmg  = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = SETTLE_LD;
                state_d  = P_CHECK;
            end
            P_CHECK: begin
                target = TGT_AI;
                if (cnt_zero) begin
                    if (AI_hp == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = THINK_LD;
                        state_d  = AI_THINK;
                    end
                end
            end
            AI_THINK: begin
                actr = ACTR_AI;
                if (cnt_zero) state_d = AI_CALC;
            end
            AI_CALC: begin
                actr     = ACTR_AI;
                calc_dmg = 1'b1;
                state_d  = AI_APPLY;
            end
            AI_APPLY: begin
                actr     = ACTR_AI;
                app_dmg  = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = SETTLE_LD;
                state_d  = AI_CHECK;
            end
            AI_CHECK: begin
                actr = ACTR_AI;
                if (cnt_zero) begin
                    if (p_hp == '0 || turn_nxt == TURN_LIM) state_d = DONE;
                    else                                     state_d = WAIT_MOVE;
                end
            end
            DONE: begin
                game_over = 1'b1;
                if (start) state_d = INIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            p_move_out <= '0;
            turn_cnt   <= '0;
            player_won <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                INIT: begin
                    turn_cnt   <= '0;
                    player_won <= 1'b0;
                end
                WAIT_MOVE: if (move_valid) p_move_out <= p_move;
                P_CHECK:   if (cnt_zero && AI_hp == '0) player_won <= 1'b1;
                AI_CHECK: begin
                    if (cnt_zero) begin
                        if (p_hp == '0) begin
                            player_won <= 1'b0;
                        end else begin
                            turn_cnt <= turn_nxt;
                            // On the turn limit a tie goes to the AI.
                            if (turn_nxt == TURN_LIM) player_won <= (p_hp > AI_hp);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pbs_ctrl.sv
// Directed bench for pbs_ctrl: a timeline model of each battle phase feeds an
// expected-output queue that is checked every cycle, plus literal spot checks.
module tb_pbs_ctrl;

    localparam int HP_W   = 4;
    localparam int MOVE_W = 2;
    localparam int THINK  = 4;
    localparam int SETTLE = 2;
    localparam int MAX_T  = 15;
    localparam int TURN_W = 4;
    localparam int VW     = 8 + TURN_W + MOVE_W;

    bit clk;
    always #5 clk = ~clk;

    logic              rst, start, move_valid;
    logic [MOVE_W-1:0] p_move;
    logic [HP_W-1:0]   p_hp, ai_hp;
    logic              move_ready, dp_rst, target, actr, calc_dmg, app_dmg, game_over, player_won;
    logic [MOVE_W-1:0] p_move_out;
    logic [TURN_W-1:0] turn_cnt;

    pbs_ctrl #(
        .HP_W(HP_W), .MOVE_W(MOVE_W), .THINK_CYCLES(THINK),
        .SETTLE_CYCLES(SETTLE), .MAX_TURNS(MAX_T), .TURN_W(TURN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .move_valid(move_valid),
        .p_move(p_move), .move_ready(move_ready), .p_move_out(p_move_out),
        .p_hp(p_hp), .AI_hp(ai_hp), .dp_rst(dp_rst), .target(target),
        .actr(actr), .calc_dmg(calc_dmg), .app_dmg(app_dmg),
        .turn_cnt(turn_cnt), .game_over(game_over), .player_won(player_won)
    );

    int vectors = 0;
    int errors  = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] cmp_e;
    logic [VW-1:0] act_vec;

    // Model of the registered results of the battle so far.
    logic              m_won, m_over;
    logic [TURN_W-1:0] m_turns;
    logic [MOVE_W-1:0] m_move;

    assign act_vec = {dp_rst, target, actr, calc_dmg, app_dmg, move_ready,
                      game_over, player_won, turn_cnt, p_move_out};

    function automatic logic [VW-1:0] ev(input logic dp, input logic tgt, input logic act,
                                         input logic calc, input logic app, input logic rdy,
                                         input logic over);
        return {dp, tgt, act, calc, app, rdy, over, m_won, m_turns, m_move};
    endfunction

    // Field order: dp_rst target actr calc app ready over won turn move
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            vectors++;
            if (act_vec !== cmp_e) begin
                errors++;
                $display("FAIL cycle_check t=%0t got %b want %b", $time, act_vec, cmp_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        errors++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "watchdog");
    end

    task automatic go(input logic [VW-1:0] v);
        @(posedge clk);
        exp_q.push_back(v);
        #1;
    endtask

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_won = 1'b0; m_over = 1'b0; m_turns = '0; m_move = '0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) go(ev(0, 0, 0, 0, 0, 0, m_over));
    endtask

    task automatic start_battle();
        start = 1'b1;
        go(ev(1, 0, 0, 0, 0, 0, 0));
        start = 1'b0;
        m_won = 1'b0; m_turns = '0; m_over = 1'b0;
        go(ev(0, 0, 0, 0, 0, 1, 0));
    endtask

    task automatic wait_move(input int n);
        move_valid = 1'b0;
        repeat (n) go(ev(0, 0, 0, 0, 0, 1, 0));
    endtask

    // One full turn starting in the move-wait phase.
    task automatic full_turn(input logic [MOVE_W-1:0] mv, input bit abort_think, input bit start_calc);
        p_move = mv; move_valid = 1'b1; m_move = mv;
        go(ev(0, 1, 0, 1, 0, 0, 0));
        move_valid = 1'b0;
        go(ev(0, 1, 0, 0, 1, 0, 0));
        repeat (SETTLE) go(ev(0, 1, 0, 0, 0, 0, 0));
        if (ai_hp == 0) begin
            m_won = 1'b1; m_over = 1'b1;
            go(ev(0, 0, 0, 0, 0, 0, 1));
            return;
        end
        go(ev(0, 0, 1, 0, 0, 0, 0));
        if (abort_think) begin
            rst = 1'b1;
            model_reset();
            go(ev(0, 0, 0, 0, 0, 0, 0));
            rst = 1'b0;
            return;
        end
        repeat (THINK - 1) go(ev(0, 0, 1, 0, 0, 0, 0));
        go(ev(0, 0, 1, 1, 0, 0, 0));
        if (start_calc) start = 1'b1;
        go(ev(0, 0, 1, 0, 1, 0, 0));
        start = 1'b0;
        repeat (SETTLE) go(ev(0, 0, 1, 0, 0, 0, 0));
        if (p_hp == 0) begin
            m_won = 1'b0; m_over = 1'b1;
            go(ev(0, 0, 0, 0, 0, 0, 1));
        end else begin
            m_turns = m_turns + 1'b1;
            if (int'(m_turns) == MAX_T) begin
                m_won = (p_hp > ai_hp); m_over = 1'b1;
                go(ev(0, 0, 0, 0, 0, 0, 1));
            end else begin
                go(ev(0, 0, 0, 0, 0, 1, 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; move_valid = 1'b0; p_move = '0;
        p_hp = 4'd9; ai_hp = 4'd9;
        model_reset();
        go(ev(0, 0, 0, 0, 0, 0, 0));
        go(ev(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        move_valid = 1'b1;
        idle_cycles(2);
        move_valid = 1'b0;
        lit("reset_game_over", 16'(game_over), 16'd0);
        lit("reset_turns", 16'(turn_cnt), 16'd0);

        start_battle();
        wait_move(10);
        lit("ready_in_wait", 16'(move_ready), 16'd1);

        full_turn(2'b10, 0, 0);
        lit("move_latched", 16'(p_move_out), 16'h2);
        lit("turn_after_one", 16'(turn_cnt), 16'd1);

        ai_hp = 4'd0;
        full_turn(2'b01, 0, 0);
        lit("player_ko_won", 16'(player_won), 16'd1);
        lit("player_ko_over", 16'(game_over), 16'd1);
        lit("player_ko_turns", 16'(turn_cnt), 16'd1);
        idle_cycles(3);

        start_battle();
        p_hp = 4'd0; ai_hp = 4'd3;
        full_turn(2'b11, 0, 0);
        lit("ai_ko_won", 16'(player_won), 16'd0);
        lit("ai_ko_over", 16'(game_over), 16'd1);
        lit("ai_ko_turns", 16'(turn_cnt), 16'd0);

        p_hp = 4'd5; ai_hp = 4'd5;
        start_battle();
        for (int i = 0; i < MAX_T; i++) full_turn(MOVE_W'(i), 0, 0);
        lit("tie_turns", 16'(turn_cnt), 16'd15);
        lit("tie_won", 16'(player_won), 16'd0);
        lit("tie_over", 16'(game_over), 16'd1);

        p_hp = 4'd6;
        start_battle();
        for (int i = 0; i < MAX_T; i++) full_turn(MOVE_W'(i + 1), 0, 0);
        lit("lead_turns", 16'(turn_cnt), 16'd15);
        lit("lead_won", 16'(player_won), 16'd1);

        p_hp = 4'd7; ai_hp = 4'd7;
        start_battle();
        full_turn(2'b01, 1, 0);
        lit("abort_outputs", 16'({dp_rst, target, actr, calc_dmg, app_dmg, move_ready, game_over, player_won}), 16'd0);
        lit("abort_move_cleared", 16'(p_move_out), 16'd0);
        idle_cycles(2);

        start_battle();
        full_turn(2'b10, 0, 1);
        lit("start_in_calc_turns", 16'(turn_cnt), 16'd1);
        lit("start_in_calc_ready", 16'(move_ready), 16'd1);
        wait_move(2);

        @(negedge clk);
        #1;
        lit("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pbs_ctrl.md
Name: pbs_ctrl

Overview:
- Battle-sequencing controller for the Pokemon battle simulator.
- Sits directly upstream of the battle datapath and drives its control inputs:
  - target select
  - attacker (trainer) select
  - damage-calculate strobe
  - damage-apply strobe
- Accepts the player's move through a valid/ready handshake, alternates player and AI turns, watches both HP values returned by the datapath, and declares the winner.

Parameters:
- HP_W, 4, width of p_hp / AI_hp.
- MOVE_W, 2, width of player move code.
- THINK_CYCLES, 4, cycles the AI "thinks" before attacking (>=1).
- SETTLE_CYCLES, 2, cycles waited after an apply strobe before HP is sampled (>=1).
- MAX_TURNS, 15, full turns before the battle ends on time (>=1, fits TURN_W).
- TURN_W, 4, width of turn counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new battle (honoured only in IDLE or DONE)
- move_valid  in  1  player move present on p_move
- p_move  in  MOVE_W  player move code
- move_ready  out  1  controller accepting a move
- p_move_out  out  MOVE_W  latched player move, to datapath
- p_hp  in  HP_W  player HP from datapath
- AI_hp  in  HP_W  AI HP from datapath
- dp_rst  out  1  one-cycle datapath HP reload pulse
- target  out  1  0 = player is damaged, 1 = AI is damaged
- actr  out  1  0 = player attacks, 1 = AI attacks
- calc_dmg  out  1  damage-calculate strobe
- app_dmg  out  1  damage-apply strobe
- turn_cnt  out  TURN_W  completed full turns this battle
- game_over  out  1  battle finished
- player_won  out  1  valid while game_over=1

Behaviour:
- Reset: state=IDLE; wait counter=0; p_move_out=0; turn_cnt=0; player_won=0. All control outputs are 0 (dp_rst, target, actr, calc_dmg, app_dmg, move_ready, game_over).
- Outputs are Moore-decoded from the state register, except the registers p_move_out, turn_cnt and player_won.
- Reset mid-operation aborts the battle with no further strobes.
- IDLE: start -> INIT.
- INIT (1 cycle): dp_rst=1; turn_cnt<=0; player_won<=0 -> WAIT_MOVE.
- WAIT_MOVE: move_ready=1, actr=0.
  - move_valid=1 -> p_move_out<=p_move, go to P_CALC.
  - Handshake completes only when valid&&ready in the same cycle; move_valid outside WAIT_MOVE is ignored.
- P_CALC (1 cycle): actr=0, target=1, calc_dmg=1 -> P_APPLY.
- P_APPLY (1 cycle): actr=0, target=1, app_dmg=1. Load counter=SETTLE_CYCLES-1 -> P_CHECK.
- P_CHECK: target=1; counter decrements each cycle. At counter==0, sample:
  - AI_hp==0 -> DONE, player_won<=1.
  - Else load counter=THINK_CYCLES-1 -> AI_THINK.
- AI_THINK: actr=1, target=0; count down; at 0 -> AI_CALC.
- AI_CALC (1 cycle): actr=1, target=0, calc_dmg=1 -> AI_APPLY.
- AI_APPLY (1 cycle): actr=1, target=0, app_dmg=1. Load counter=SETTLE_CYCLES-1 -> AI_CHECK.
- AI_CHECK: count down; at 0:
  - p_hp==0 -> DONE, player_won<=0.
  - Else turn_cnt<=turn_cnt+1. If the new value ==MAX_TURNS -> DONE, player_won<=(p_hp>AI_hp); a tie means the AI wins.
  - Else -> WAIT_MOVE.
- DONE: game_over=1; player_won held; start -> INIT. start in any other state is ignored.
- Invariants:
  - calc_dmg and app_dmg are never high together.
  - Each attack is exactly one calc pulse followed by one apply pulse.
  - turn_cnt never wraps; MAX_TURNS ends the battle first.
- HP already 0 at INIT+1 is not checked until the first CHECK state.

Decomposition:
- Package pbs_pkg holds:
  - the state enum (IDLE, INIT, WAIT_MOVE, P_CALC, P_APPLY, P_CHECK, AI_THINK, AI_CALC, AI_APPLY, AI_CHECK, DONE)
  - constants TGT_PLAYER=0, TGT_AI=1, ACTR_PLAYER=0, ACTR_AI=1
  - default HP_W / MOVE_W
- One sub-module, pbs_wait_cnt: a loadable down-counter with load, load value and zero flag, shared by the THINK and CHECK states.

Test Plan:
- Reset then start → dp_rst high for exactly 1 cycle, then move_ready=1. Hold move_valid=0 for 10 cycles → no strobes.
- p_move=2'b10, move_valid=1 → p_move_out=2'b10. P_CALC then P_APPLY: calc_dmg (actr=0,target=1) one cycle, then app_dmg one cycle. AI calc/apply (actr=1,target=0) follows 2+4 cycles later.
- Force AI_hp=0 before P_CHECK sampling → DONE, game_over=1, player_won=1, no AI strobes issued.
- Force p_hp=0 at AI_CHECK → game_over=1, player_won=0, turn_cnt unchanged.
- Keep both HP nonzero, p_hp=5, AI_hp=5 → after 15 turns DONE with player_won=0 (tie). Rerun with p_hp=6 → player_won=1.
- Assert rst in AI_THINK → next cycle all outputs 0, state IDLE. start while in AI_CALC → ignored.
